// File: rtl/dcache_2way_ctrl.sv
// Write-back, write-allocate 2-way set-associative D-cache: word hits complete in the same cycle.
// A miss stalls MEM_LAT+2 cycles (clean) or 2*MEM_LAT+2 (dirty victim); stall_o holds the CPU.
module dcache_2way_ctrl #(
  parameter int SETS    = 16,
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [3:0]   cpu_sel_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         stall_o,
  output logic         mem_ce_o,
  output logic         mem_we_o,
  output logic [29:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_block_i
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 27 - IDX_W;
  localparam int CNT_W = $clog2(MEM_LAT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL, S_FILL} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [255:0]       r_data [2][SETS];
  logic [TAG_W-1:0]   r_tag  [2][SETS];
  logic [SETS-1:0]    r_valid [2];
  logic [SETS-1:0]    r_dirty [2];
  logic [SETS-1:0]    r_lru;
  logic               r_vic;
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_W-1:0]   r_mtag;
  logic               r_mem_ce, r_mem_we;
  logic [29:0]        r_mem_addr;
  logic [255:0]       r_mem_wdata;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [2:0]         w_word;
  logic               w_hit0, w_hit1, w_hit, w_hway;
  logic               w_vic, w_vic_dirty, w_cnt_done, w_acc, w_miss;
  logic [255:0]       w_hblk;
  logic               w_unused;

  assign w_idx       = cpu_addr_i[IDX_W+4:5];
  assign w_tag       = cpu_addr_i[31:IDX_W+5];
  assign w_word      = cpu_addr_i[4:2];
  assign w_unused    = ^cpu_addr_i[1:0];
  assign w_hit0      = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1      = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit       = w_hit0 || w_hit1;
  assign w_hway      = w_hit1;
  assign w_hblk      = w_hway ? r_data[1][w_idx] : r_data[0][w_idx];
  // Fill invalid ways in order before evicting by LRU.
  assign w_vic       = !r_valid[0][w_idx] ? 1'b0 : (!r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx]);
  assign w_vic_dirty = r_valid[w_vic][w_idx] && r_dirty[w_vic][w_idx];
  assign w_cnt_done  = (r_cnt == CNT_W'(MEM_LAT - 1));
  assign w_acc       = (r_state == S_IDLE) && cpu_req_i && w_hit;
  assign w_miss      = (r_state == S_IDLE) && cpu_req_i && !w_hit;

  assign mem_ce_o    = r_mem_ce;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

  always_comb begin
    w_next      = r_state;
    stall_o     = 1'b0;
    cpu_rdata_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          stall_o = 1'b1;
          w_next  = w_vic_dirty ? S_WB : S_REFILL;
        end else if (w_acc && !cpu_we_i) begin
          cpu_rdata_o = w_hblk[{w_word, 5'b0} +: 32];
        end
      end
      S_WB: begin
        stall_o = 1'b1;
        if (w_cnt_done) w_next = S_REFILL;
      end
      S_REFILL: begin
        stall_o = 1'b1;
        if (w_cnt_done) w_next = S_FILL;
      end
      S_FILL: begin
        stall_o = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
    end
  end

  // Memory interface is registered from the next state so it stays constant within a state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_ce <= (w_next == S_WB) || (w_next == S_REFILL);
      r_mem_we <= (w_next == S_WB);
      if (r_state == S_IDLE && w_next == S_WB) begin
        r_mem_addr  <= {3'b0, r_tag[w_vic][w_idx], w_idx};
        r_mem_wdata <= r_data[w_vic][w_idx];
      end else if (r_state == S_IDLE && w_next == S_REFILL) begin
        r_mem_addr <= {3'b0, cpu_addr_i[31:5]};
      end else if (r_state == S_WB && w_next == S_REFILL) begin
        r_mem_addr <= {3'b0, r_mtag, r_idx};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru      <= '0;
    end else begin
      if (w_acc) begin
        r_lru[w_idx] <= ~w_hway;
        if (cpu_we_i) r_dirty[w_hway][w_idx] <= 1'b1;
      end
      if (r_state == S_WB && w_cnt_done) r_dirty[r_vic][r_idx] <= 1'b0;
      if (r_state == S_FILL) begin
        r_valid[r_vic][r_idx] <= 1'b1;
        r_dirty[r_vic][r_idx] <= 1'b0;
      end
    end
  end

  // The miss is captured so the fill completes even if the CPU drops its request.
  always_ff @(posedge clk) begin
    if (w_miss) begin
      r_vic  <= w_vic;
      r_idx  <= w_idx;
      r_mtag <= w_tag;
    end
    if (!rst && r_state == S_FILL) begin
      r_data[r_vic][r_idx] <= mem_block_i;
      r_tag[r_vic][r_idx]  <= r_mtag;
    end
    if (!rst && w_acc && cpu_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_sel_i[b]) r_data[w_hway][w_idx][{w_word, b[1:0], 3'b0} +: 8] <= cpu_wdata_i[b*8 +: 8];
      end
    end
  end
endmodule
